rx_byte_ctrl: RTL and testbench

RX_BYTE_CTRL -- requirements
Module: rx_byte_ctrl

---
 rtl/rx_byte_ctrl.sv | 152 +++++++++++++++
 tb/tb_rx_byte_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_byte_ctrl.sv
// rx_byte_ctrl: packet-level receive controller that sits behind a byte
// deserializer. It steers a 2-byte holding buffer and the RX FIFO write
// strobe, tracks the packet phase and reports errors and completion.
// Optional feature macro: PID_CHECK_EN enables the PID complement check.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a start-of-packet edge
// SYNC     | expecting the sync byte
// PID      | expecting the PID byte
// DATA     | receiving payload and CRC16 bytes
// ERR_WAIT | packet rejected, discarding bytes until end of packet
module rx_byte_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'h80,
  parameter int         MAX_BYTES = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       byte_received,
  input  logic [7:0] p_out,
  input  logic       eop,
  output logic       load_buf,
  output logic       flush,
  output logic       w_enable,
  output logic       rcving,
  output logic       r_error,
  output logic       rx_done,
  output logic [3:0] pid_out
);

  // Payload plus the two CRC bytes; the counter must also hold this value.
  localparam int LIMIT = MAX_BYTES + 2;
  localparam int CW    = $clog2(LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SYNC     = 3'd1,
    PID      = 3'd2,
    DATA     = 3'd3,
    ERR_WAIT = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          err_n;
  logic          flush_n;
  logic          done_n;
  logic [3:0]    pid_n;
  logic          pid_ok;

`ifdef PID_CHECK_EN
  assign pid_ok = (p_out[7:4] == ~p_out[3:0]);
`else
  assign pid_ok = 1'b1;
`endif

  assign rcving = (state != IDLE);

  // State, counter and registered status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      r_error <= 1'b0;
      flush   <= 1'b0;
      rx_done <= 1'b0;
      pid_out <= 4'h0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      r_error <= err_n;
      flush   <= flush_n;
      rx_done <= done_n;
      pid_out <= pid_n;
    end
  end

  // Next-state decode; eop always wins over a coincident byte strobe.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    err_n    = r_error;
    pid_n    = pid_out;
    flush_n  = 1'b0;
    done_n   = 1'b0;
    load_buf = 1'b0;
    w_enable = 1'b0;
    case (state)
      IDLE: begin
        if (d_edge) begin
          state_n = SYNC;
          flush_n = 1'b1;
          err_n   = 1'b0;
        end
      end
      SYNC: begin
        if (eop) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (byte_received) begin
          if (p_out == SYNC_BYTE) begin
            state_n = PID;
          end else begin
            state_n = ERR_WAIT;
            err_n   = 1'b1;
          end
        end
      end
      PID: begin
        if (eop) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (byte_received) begin
          if (pid_ok) begin
            // The PID also enters the buffer; it is shifted out before
            // any FIFO write because writes start at the third data byte.
            state_n  = DATA;
            pid_n    = p_out[3:0];
            cnt_n    = '0;
            load_buf = 1'b1;
          end else begin
            state_n = ERR_WAIT;
            err_n   = 1'b1;
          end
        end
      end
      DATA: begin
        if (eop) begin
          state_n = IDLE;
          if (cnt == CW'(1)) err_n  = 1'b1;
          else               done_n = 1'b1;
        end else if (byte_received) begin
          load_buf = 1'b1;
          if (cnt == CW'(LIMIT)) begin
            // Overlong packet: counter stays saturated, nothing is written.
            state_n = ERR_WAIT;
            err_n   = 1'b1;
          end else begin
            cnt_n    = cnt + CW'(1);
            w_enable = (cnt >= CW'(2));
          end
        end
      end
      ERR_WAIT: begin
        if (eop) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rx_byte_ctrl.sv
// Bench for rx_byte_ctrl: a vector table for a good packet plus
// hand-written sequences for the error and reset corner cases.
module tb_rx_byte_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_edge, byte_received, eop;
  logic [7:0] p_out;
  logic       load_buf, flush, w_enable, rcving, r_error, rx_done;
  logic [3:0] pid_out;
  logic       load_buf2, flush2, w_enable2, rcving2, r_error2, rx_done2;
  logic [3:0] pid_out2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rx_byte_ctrl dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_received(byte_received),
    .p_out(p_out), .eop(eop), .load_buf(load_buf), .flush(flush),
    .w_enable(w_enable), .rcving(rcving), .r_error(r_error),
    .rx_done(rx_done), .pid_out(pid_out)
  );

  rx_byte_ctrl #(.MAX_BYTES(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .byte_received(byte_received),
    .p_out(p_out), .eop(eop), .load_buf(load_buf2), .flush(flush2),
    .w_enable(w_enable2), .rcving(rcving2), .r_error(r_error2),
    .rx_done(rx_done2), .pid_out(pid_out2)
  );

  // External 2-byte buffer that the controller steers; rcv_data is the
  // older byte, which is what the FIFO receives on w_enable.
  logic [7:0] hold [2];
  logic [7:0] rcv_data;
  assign rcv_data = hold[0];

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hold[0] <= 8'h00;
      hold[1] <= 8'h00;
    end else if (flush) begin
      hold[0] <= 8'h00;
      hold[1] <= 8'h00;
    end else if (load_buf) begin
      hold[0] <= hold[1];
      hold[1] <= p_out;
    end
  end

  typedef struct {
    logic       de;
    logic       br;
    logic [7:0] pb;
    logic       ep;
    logic [4:0] exp;   // {load_buf, w_enable, rcving, flush, rx_done}
    logic [7:0] wd;    // expected rcv_data when w_enable is expected
  } vec_t;

  vec_t tbl [9];
  vec_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return 2ns later so
  // callers can sample both combinational and settled registered outputs.
  task automatic step(input logic de, input logic br, input logic [7:0] pb, input logic ep);
    @(negedge clk);
    d_edge = de; byte_received = br; p_out = pb; eop = ep;
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic rx(input logic [7:0] b);
    step(1'b0, 1'b1, b, 1'b0);
  endtask

  int wen_cnt;
  vec_t v;

  initial begin
    n_rst = 1'b0; d_edge = 1'b0; byte_received = 1'b0; p_out = 8'h00; eop = 1'b0;
    //               de br  pb    ep  lb we rc fl dn   wd
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'b00000, 8'h00};
    tbl[1] = '{1'b0, 1'b1, 8'h80, 1'b0, 5'b00110, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 8'hC3, 1'b0, 5'b10100, 8'h00};
    tbl[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 5'b10100, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 8'h22, 1'b0, 5'b10100, 8'h00};
    tbl[5] = '{1'b0, 1'b1, 8'h33, 1'b0, 5'b11100, 8'h11};
    tbl[6] = '{1'b0, 1'b1, 8'h44, 1'b0, 5'b11100, 8'h22};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'b00100, 8'h00};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'b00001, 8'h00};

    #3;
    check("reset_outputs", {27'd0, load_buf, w_enable, rcving, r_error, rx_done}, 32'd0);
    check("reset_flush_pid", {27'd0, flush, pid_out}, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    idle();

    // Good packet: 80 C3 11 22 33 44 eop.
    for (int i = 0; i < 9; i++) begin
      sb.push_back(tbl[i]);
      step(tbl[i].de, tbl[i].br, tbl[i].pb, tbl[i].ep);
      v = sb.pop_front();
      check($sformatf("good_row%0d", i),
            {27'd0, load_buf, w_enable, rcving, flush, rx_done}, {27'd0, v.exp});
      if (v.exp[3]) check($sformatf("good_wdata%0d", i), {24'd0, rcv_data}, {24'd0, v.wd});
    end
    check("good_pid", {28'd0, pid_out}, 32'd3);
    check("good_err", {31'd0, r_error}, 32'd0);

    // Bad sync byte, bytes ignored in ERR_WAIT, error sticky through eop.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rx(8'h81);
    idle();
    check("badsync_err", {30'd0, rcving, r_error}, 32'd3);
    rx(8'h55);
    check("errwait_noload", {30'd0, load_buf, w_enable}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    check("errwait_dedge_ignored", {31'd0, flush}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    check("errwait_eop_idle", {30'd0, rcving, r_error}, 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    idle();
    check("dedge_clears_err", {30'd0, flush, r_error}, 32'd2);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    check("eop_in_sync_err", {30'd0, rcving, r_error}, 32'd1);

    // PID C4: rejected only when the complement check is built in.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rx(8'h80);
    rx(8'hC4);
    idle();
`ifdef PID_CHECK_EN
    check("pid_c4_err", {31'd0, r_error}, 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
`else
    check("pid_c4_ok", {27'd0, r_error, pid_out}, 32'd4);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    check("zero_len_done", {30'd0, rx_done, r_error}, 32'd2);
`endif

    // eop after a single data byte is a malformed packet.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rx(8'h80); rx(8'hC3); rx(8'h11);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    check("eop_cnt1_err", {30'd0, rx_done, r_error}, 32'd1);

    // Overlong packet on the MAX_BYTES=2 instance.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rx(8'h80); rx(8'hC3);
    wen_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      rx(8'hA0 + 8'(i));
      if (w_enable2) wen_cnt++;
      if (i == 4) check("overlong_5th_nowen", {31'd0, w_enable2}, 32'd0);
    end
    idle();
    check("overlong_wen_count", wen_cnt, 32'd2);
    check("overlong_err", {30'd0, rcving2, r_error2}, 32'd3);
    check("max64_no_err", {31'd0, r_error}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle();

    // eop coincident with the third data byte: byte discarded, packet good.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rx(8'h80); rx(8'hC3); rx(8'h11); rx(8'h22);
    step(1'b0, 1'b1, 8'h33, 1'b1);
    check("eop_byte_noload", {30'd0, load_buf, w_enable}, 32'd0);
    idle();
    check("eop_byte_done", {29'd0, rcving, rx_done, r_error}, 32'd2);

    // Reset in the middle of DATA.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rx(8'h80); rx(8'hC5); rx(8'h11);
    @(negedge clk);
    byte_received = 1'b1; p_out = 8'h22;
    n_rst = 1'b0;
    #1;
    check("midreset_outputs", {26'd0, load_buf, flush, w_enable, rcving, r_error, rx_done}, 32'd0);
    check("midreset_pid", {28'd0, pid_out}, 32'd0);
    @(negedge clk);
    byte_received = 1'b0;
    n_rst = 1'b1;
    rx(8'h80);
    check("after_reset_idle", {30'd0, rcving, load_buf}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
